// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   state_e        : controller state encoding (StIdle = no owner, StOwn = grant held)
//   HoldMaxDefault : default tenure limit while another requester waits
//   pick_t/rr_pick : rotating first-set search over a 4-bit request vector
//   onehot4        : 2-bit index to 4-bit one-hot
package rr_mux_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } state_e;

    localparam int unsigned HoldMaxDefault = 4;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // First set bit of cand, searching start, start+1, ... modulo 4.
    // Iterates from the farthest offset down so the nearest hit is written last.
    function automatic pick_t rr_pick(input logic [3:0] cand, input logic [1:0] start);
        pick_t      p;
        logic [1:0] c;
        p.found = 1'b0;
        p.idx   = start;
        for (int k = 3; k >= 0; k--) begin
            c = start + 2'(k);
            if (cand[c]) begin
                p.found = 1'b1;
                p.idx   = c;
            end
        end
        return p;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux4_w.sv
// mux4_w: combinational WIDTH-bit 4:1 multiplexer.
//   d0..d3 : data inputs
//   sel    : select, 2'd0 picks d0
//   y      : selected data
module mux4_w #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = d0;
        unique case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: four-requester round-robin arbiter driving a shared registered 4:1 mux.
// An owner keeps the grant while it requests, but after HOLD_MAX consecutive cycles it
// yields to any other waiting requester.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   req       : request per requester
//   d0..d3    : requester data
//   grant     : one-hot owner, zero when idle
//   sel       : owner index (mux select), held while idle
//   out_data  : registered mux output, held while idle
//   out_valid : out_data carries a live owner's data
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_MAX = HoldMaxDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

    state_e           state;
    logic [1:0]       ptr;
    logic [7:0]       hold;
    logic [WIDTH-1:0] mux_y;
    pick_t            pick_any;
    pick_t            pick_rot;

    mux4_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (sel),
        .y   (mux_y)
    );

    // pick_rot excludes the current owner so a rotation only lands on someone else.
    assign pick_any = rr_pick(req, ptr);
    assign pick_rot = rr_pick(req & ~grant, ptr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            grant     <= 4'b0000;
            sel       <= 2'd0;
            ptr       <= 2'd0;
            hold      <= 8'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == StOwn) begin
                out_data <= mux_y;
            end
            out_valid <= (state == StOwn) && req[sel];

            case (state)
                StIdle: begin
                    if (pick_any.found) begin
                        state <= StOwn;
                        grant <= onehot4(pick_any.idx);
                        sel   <= pick_any.idx;
                        ptr   <= pick_any.idx + 2'd1;
                        hold  <= 8'd0;
                    end
                end
                StOwn: begin
                    if (!req[sel]) begin
                        // Owner released: hand over directly, or fall idle with sel held.
                        if (pick_any.found) begin
                            grant <= onehot4(pick_any.idx);
                            sel   <= pick_any.idx;
                            ptr   <= pick_any.idx + 2'd1;
                        end else begin
                            state <= StIdle;
                            grant <= 4'b0000;
                        end
                        hold <= 8'd0;
                    end else if (hold < HoldLast) begin
                        hold <= hold + 8'd1;
                    end else if (pick_rot.found) begin
                        grant <= onehot4(pick_rot.idx);
                        sel   <= pick_rot.idx;
                        ptr   <= pick_rot.idx + 2'd1;
                        hold  <= 8'd0;
                    end else begin
                        // Nobody else waiting: restart the tenure window.
                        hold <= 8'd0;
                    end
                end
                default: begin
                    state <= StIdle;
                    grant <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios followed by random traffic. Each driven
// cycle pushes the reference model's expected post-edge outputs; a negedge monitor pops
// and compares them against the DUT.
module tb_rr_mux_arbiter;

    localparam int WIDTH    = 8;
    localparam int HOLD_MAX = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;

    always #5 clk = ~clk;

    rr_mux_arbiter #(
        .WIDTH    (WIDTH),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .grant     (grant),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    typedef struct packed {
        logic [3:0]       grant;
        logic [1:0]       sel;
        logic             valid;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: owner -1 means nobody holds the grant.
    int               m_owner = -1;
    int               m_ptr   = 0;
    int               m_hold  = 0;
    int               m_sel   = 0;
    logic [WIDTH-1:0] m_data  = '0;
    logic             m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            automatic int i = (start + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic take_grant(input int n);
        m_owner = n;
        m_sel   = n;
        m_ptr   = (n + 1) % 4;
        m_hold  = 0;
    endtask

    // Apply inputs for the next edge, predict the outputs after it, then step past it.
    task automatic drive(input logic rst_v, input logic [3:0] r);
        logic [WIDTH-1:0] dv [4];
        int               n;
        exp_t             e;
        dv[0] = WIDTH'($urandom);
        dv[1] = WIDTH'($urandom);
        dv[2] = WIDTH'($urandom);
        dv[3] = WIDTH'($urandom);
        rst_n = rst_v;
        req   = r;
        d0    = dv[0];
        d1    = dv[1];
        d2    = dv[2];
        d3    = dv[3];

        if (!rst_v) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_sel   = 0;
            m_data  = '0;
            m_valid = 1'b0;
        end else begin
            m_valid = (m_owner >= 0) && r[m_sel];
            if (m_owner >= 0) m_data = dv[m_sel];
            if (m_owner < 0) begin
                n = first_from(r, m_ptr);
                if (n >= 0) take_grant(n);
            end else if (!r[m_owner]) begin
                n = first_from(r, m_ptr);
                if (n >= 0) take_grant(n);
                else begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end else if (m_hold < HOLD_MAX - 1) begin
                m_hold++;
            end else begin
                n = first_from(r & ~(4'b0001 << m_owner), m_ptr);
                if (n >= 0) take_grant(n);
                else m_hold = 0;
            end
        end

        e.grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.sel   = 2'(m_sel);
        e.valid = m_valid;
        e.data  = m_data;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT against the oldest pending expectation.
    initial begin
        exp_t e;
        int   gi;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", 32'(grant), 32'(e.grant));
                check("sel", 32'(sel), 32'(e.sel));
                check("out_valid", 32'(out_valid), 32'(e.valid));
                check("out_data", 32'(out_data), 32'(e.data));
                check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                if (grant != 4'b0000) begin
                    gi = 0;
                    for (int i = 0; i < 4; i++) if (grant[i]) gi = i;
                    check("sel_matches_grant", 32'(sel), 32'(gi));
                end
            end
        end
    end

    initial begin
        logic [3:0] rq;
        logic       rs;

        // Reset, then a single requester (grant then data one cycle later).
        repeat (2) drive(1'b0, 4'b0000);
        repeat (3) drive(1'b1, 4'b0001);
        repeat (2) drive(1'b1, 4'b0000);

        // All requesting: rotation every HOLD_MAX cycles.
        repeat (18) drive(1'b1, 4'b1111);

        // Owner 2 (ptr=3) releases while 0 and 1 wait: wraps to 0 with no idle cycle.
        drive(1'b0, 4'b0000);
        repeat (3) drive(1'b1, 4'b0100);
        repeat (4) drive(1'b1, 4'b0011);

        // Lone requester keeps the grant past the tenure limit.
        repeat (20) drive(1'b1, 4'b0010);

        // Reset in the middle of owner 3's tenure, then re-grant.
        repeat (3) drive(1'b1, 4'b1000);
        drive(1'b0, 4'b1000);
        repeat (3) drive(1'b1, 4'b1000);

        // Random traffic with sticky requests and occasional reset.
        rq = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 49) != 0);
            drive(rs, rq);
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
